// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweep checker.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    function automatic int tt_table_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_sweep_counter.sv
// Minterm index register plus settle timer for the truth-table sweep.
module tt_sweep_counter
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            advance,
    input  logic            count_en,
    output logic [N_IN-1:0] idx,
    output logic            last,
    output logic            settled
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // One spare bit so the terminal compare can never alias after a wrap.
    localparam logic [N_IN:0] LAST_IDX = {1'b0, {N_IN{1'b1}}};

    logic [N_IN:0] idx_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            cnt   <= '0;
        end else begin
            if (clear)
                idx_q <= '0;
            else if (advance)
                idx_q <= idx_q + 1'b1;

            if (clear || !count_en)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    assign idx     = idx_q[N_IN-1:0];
    assign last    = (idx_q == LAST_IDX);
    assign settled = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input combinations over two functions, captures both truth tables
// and reports equivalence plus the lowest differing minterm.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic [N_IN-1:0]                 stim,
    input  logic                            f1_in,
    input  logic                            f2_in,
    output logic                            busy,
    output logic                            done,
    output logic                            equal,
    output logic [tt_table_width(N_IN)-1:0] table1,
    output logic [tt_table_width(N_IN)-1:0] table2,
    output logic                            mismatch_valid,
    output logic [N_IN-1:0]                 first_mismatch
);

    tt_state_e       state, state_nxt;
    logic [N_IN-1:0] idx;
    logic            last, settled;
    logic            clear, advance, count_en;
    logic            diff;

    tt_sweep_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .advance  (advance),
        .count_en (count_en),
        .idx      (idx),
        .last     (last),
        .settled  (settled)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        advance   = 1'b0;
        count_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    clear     = 1'b1;
                end
            end
            DRIVE: begin
                if (settled)
                    state_nxt = SAMPLE;
                else
                    count_en = 1'b1;
            end
            SAMPLE: begin
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stim = idx;
    assign done = (state == DONE);
    assign diff = f1_in ^ f2_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy           <= 1'b0;
            equal          <= 1'b0;
            table1         <= '0;
            table2         <= '0;
            mismatch_valid <= 1'b0;
            first_mismatch <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        equal          <= 1'b0;
                        table1         <= '0;
                        table2         <= '0;
                        mismatch_valid <= 1'b0;
                        first_mismatch <= '0;
                    end
                end
                SAMPLE: begin
                    table1[idx] <= f1_in;
                    table2[idx] <= f2_in;
                    // Only the first difference is latched, giving the lowest index.
                    if (diff && !mismatch_valid) begin
                        mismatch_valid <= 1'b1;
                        first_mismatch <= idx;
                    end
                    if (last) begin
                        equal <= !(mismatch_valid || diff);
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
